// File: rtl/fpu_offload_pkg.sv
// Shared types, opcode constants and the FP-opcode classifier for the
// rvfpm offload controller.
package fpu_offload_pkg;

  localparam int ID_W = 4;

  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic       busy;
    logic [4:0] rd;
  } entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  function automatic logic is_fp_opcode(input logic [6:0] opc);
    return (opc == OPC_LOAD_FP) || (opc == OPC_STORE_FP) || (opc == OPC_OP_FP) ||
           (opc == OPC_FMADD)   || (opc == OPC_FMSUB)    || (opc == OPC_FNMSUB) ||
           (opc == OPC_FNMADD);
  endfunction

endpackage

// File: rtl/fpu_offload_if.sv
// Issue, FPU request/response and writeback/store signals bundled between
// the core side (master) and the offload controller (slave).
interface fpu_offload_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int FLEN       = 32
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic                  issue_accept;
  logic [31:0]           issue_instr;
  logic [XLEN-1:0]       issue_rs1;
  logic [FLEN-1:0]       issue_memdata;

  logic                  fpu_enable;
  logic [31:0]           fpu_instruction;
  logic [X_ID_WIDTH-1:0] fpu_id;
  logic [XLEN-1:0]       fpu_fromXReg;
  logic [FLEN-1:0]       fpu_fromMem;
  logic                  fpu_ready;
  logic [X_ID_WIDTH-1:0] fpu_id_out;
  logic [XLEN-1:0]       fpu_toXReg;
  logic                  fpu_toXReg_valid;
  logic [FLEN-1:0]       fpu_toMem;
  logic                  fpu_toMem_valid;

  logic                  wb_valid;
  logic [4:0]            wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic [X_ID_WIDTH-1:0] wb_id;
  logic                  st_valid;
  logic [FLEN-1:0]       st_data;
  logic [X_ID_WIDTH-1:0] st_id;

  modport slave (
    input  issue_valid, issue_instr, issue_rs1, issue_memdata,
           fpu_ready, fpu_id_out, fpu_toXReg, fpu_toXReg_valid, fpu_toMem, fpu_toMem_valid,
    output issue_ready, issue_accept,
           fpu_enable, fpu_instruction, fpu_id, fpu_fromXReg, fpu_fromMem,
           wb_valid, wb_rd, wb_data, wb_id, st_valid, st_data, st_id
  );

  modport master (
    output issue_valid, issue_instr, issue_rs1, issue_memdata,
           fpu_ready, fpu_id_out, fpu_toXReg, fpu_toXReg_valid, fpu_toMem, fpu_toMem_valid,
    input  issue_ready, issue_accept,
           fpu_enable, fpu_instruction, fpu_id, fpu_fromXReg, fpu_fromMem,
           wb_valid, wb_rd, wb_data, wb_id, st_valid, st_data, st_id
  );
endinterface

// File: rtl/fpu_offload_ctrl_id_table.sv
// Transaction-ID table: per-ID busy flag and destination register, the
// in-flight counter and a sticky flag for results carrying a free ID.
module fpu_id_table
  import fpu_offload_pkg::*;
#(
  parameter int X_ID_WIDTH = 4
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  i_alloc,
  input  logic [X_ID_WIDTH-1:0] i_alloc_id,
  input  logic [4:0]            i_alloc_rd,
  input  logic                  i_ret_valid,
  input  logic [X_ID_WIDTH-1:0] i_ret_id,
  output logic                  o_alloc_busy,
  output logic                  o_ret_busy,
  output logic [4:0]            o_ret_rd,
  output logic [X_ID_WIDTH:0]   o_outstanding,
  output logic                  o_id_err
);
  localparam int DEPTH = 2 ** X_ID_WIDTH;

  entry_t                r_table [DEPTH];
  logic [X_ID_WIDTH:0]   r_count;
  logic                  r_id_err;
  logic                  w_ret_hit;

  assign o_alloc_busy  = r_table[i_alloc_id].busy;
  assign o_ret_busy    = r_table[i_ret_id].busy;
  assign o_ret_rd      = r_table[i_ret_id].rd;
  assign o_outstanding = r_count;
  assign o_id_err      = r_id_err;
  assign w_ret_hit     = i_ret_valid && o_ret_busy;

  // Allocation never targets a busy entry, so it cannot collide with a retire.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
      r_count  <= '0;
      r_id_err <= 1'b0;
    end else begin
      if (w_ret_hit) r_table[i_ret_id].busy <= 1'b0;
      if (i_alloc)   r_table[i_alloc_id]    <= '{busy: 1'b1, rd: i_alloc_rd};
      case ({i_alloc, w_ret_hit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_ret_valid && !o_ret_busy) r_id_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fpu_offload_ctrl.sv
// Core-side issuer for the rvfpm FPU: filters FP instructions, tags them with
// IDs, pumps bubbles while work is in flight and routes results back by ID.
module fpu_offload_ctrl
  import fpu_offload_pkg::*;
#(
  parameter int          X_ID_WIDTH      = 4,
  parameter int          XLEN            = 32,
  parameter int          FLEN            = 32,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [31:0] BUBBLE_INSN     = 32'h0000_0013
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                i_drain,
  fpu_offload_if.slave        if_bus,
  output logic [X_ID_WIDTH:0] o_outstanding,
  output logic                o_id_err
);
  localparam logic [X_ID_WIDTH:0] MAX_CNT = (X_ID_WIDTH + 1)'(MAX_OUTSTANDING);

  state_t                r_state, w_state_next;
  logic [X_ID_WIDTH-1:0] r_next_id;
  logic                  w_is_fp, w_fp_ok, w_alloc, w_alloc_busy;
  logic                  w_ret_valid, w_ret_busy;
  logic [4:0]            w_ret_rd;

  logic                  r_fpu_enable;
  logic [31:0]           r_fpu_instruction;
  logic [X_ID_WIDTH-1:0] r_fpu_id;
  logic [XLEN-1:0]       r_fpu_from_x;
  logic [FLEN-1:0]       r_fpu_from_mem;
  logic                  r_wb_valid, r_st_valid;
  logic [4:0]            r_wb_rd;
  logic [XLEN-1:0]       r_wb_data;
  logic [X_ID_WIDTH-1:0] r_wb_id, r_st_id;
  logic [FLEN-1:0]       r_st_data;

  assign w_is_fp     = is_fp_opcode(if_bus.issue_instr[6:0]);
  assign w_fp_ok     = (r_state == ST_RUN) && if_bus.fpu_ready && !w_alloc_busy &&
                       (o_outstanding < MAX_CNT);
  assign w_alloc     = if_bus.issue_valid && w_is_fp && w_fp_ok;
  assign w_ret_valid = if_bus.fpu_toXReg_valid || if_bus.fpu_toMem_valid;

  // Non-FP words are always taken and stay in the core; accept flags FP only.
  assign if_bus.issue_ready  = if_bus.issue_valid && (w_is_fp ? w_fp_ok : 1'b1);
  assign if_bus.issue_accept = if_bus.issue_valid && w_is_fp;

  fpu_id_table #(.X_ID_WIDTH(X_ID_WIDTH)) u_table (
    .ck            (ck),
    .rst           (rst),
    .i_alloc       (w_alloc),
    .i_alloc_id    (r_next_id),
    .i_alloc_rd    (if_bus.issue_instr[11:7]),
    .i_ret_valid   (w_ret_valid),
    .i_ret_id      (if_bus.fpu_id_out),
    .o_alloc_busy  (w_alloc_busy),
    .o_ret_busy    (w_ret_busy),
    .o_ret_rd      (w_ret_rd),
    .o_outstanding (o_outstanding),
    .o_id_err      (o_id_err)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  // Leaving DRAIN waits for the pipeline to be empty as well as drain low.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (i_drain) w_state_next = ST_DRAIN;
      ST_DRAIN: if (!i_drain && o_outstanding == '0) w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst)          r_next_id <= '0;
    else if (w_alloc) r_next_id <= r_next_id + 1'b1;
  end

  // Bubbles keep the FPU stepping so in-flight results drain without new issues.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_fpu_enable      <= 1'b0;
      r_fpu_instruction <= '0;
      r_fpu_id          <= '0;
      r_fpu_from_x      <= '0;
      r_fpu_from_mem    <= '0;
    end else if (w_alloc) begin
      r_fpu_enable      <= 1'b1;
      r_fpu_instruction <= if_bus.issue_instr;
      r_fpu_id          <= r_next_id;
      r_fpu_from_x      <= if_bus.issue_rs1;
      r_fpu_from_mem    <= if_bus.issue_memdata;
    end else if (o_outstanding != '0 && if_bus.fpu_ready) begin
      r_fpu_enable      <= 1'b1;
      r_fpu_instruction <= BUBBLE_INSN;
      r_fpu_id          <= '0;
      r_fpu_from_x      <= '0;
      r_fpu_from_mem    <= '0;
    end else begin
      r_fpu_enable      <= 1'b0;
      r_fpu_instruction <= '0;
      r_fpu_id          <= '0;
      r_fpu_from_x      <= '0;
      r_fpu_from_mem    <= '0;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_id    <= '0;
      r_st_valid <= 1'b0;
      r_st_data  <= '0;
      r_st_id    <= '0;
    end else begin
      r_wb_valid <= if_bus.fpu_toXReg_valid && w_ret_busy;
      r_wb_rd    <= w_ret_rd;
      r_wb_data  <= if_bus.fpu_toXReg;
      r_wb_id    <= if_bus.fpu_id_out;
      r_st_valid <= if_bus.fpu_toMem_valid && w_ret_busy;
      r_st_data  <= if_bus.fpu_toMem;
      r_st_id    <= if_bus.fpu_id_out;
    end
  end

  assign if_bus.fpu_enable      = r_fpu_enable;
  assign if_bus.fpu_instruction = r_fpu_instruction;
  assign if_bus.fpu_id          = r_fpu_id;
  assign if_bus.fpu_fromXReg    = r_fpu_from_x;
  assign if_bus.fpu_fromMem     = r_fpu_from_mem;
  assign if_bus.wb_valid        = r_wb_valid;
  assign if_bus.wb_rd           = r_wb_rd;
  assign if_bus.wb_data         = r_wb_data;
  assign if_bus.wb_id           = r_wb_id;
  assign if_bus.st_valid        = r_st_valid;
  assign if_bus.st_data         = r_st_data;
  assign if_bus.st_id           = r_st_id;

endmodule

// File: tb/tb_fpu_offload_ctrl.sv
// Scoreboard bench for fpu_offload_ctrl: a small ID-table model predicts
// handshakes, pumping and counts; queues hold expected FPU issues and results.
module tb_fpu_offload_ctrl;
  import fpu_offload_pkg::*;

  localparam logic [31:0] BUBBLE = 32'h0000_0013;
  localparam logic [31:0] ADDI   = 32'h0010_0093;

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  id;
    logic [31:0] rs1;
    logic [31:0] mem;
  } issueExp_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  id;
  } wbExp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
  } stExp_t;

  logic       ck = 1'b0;
  logic       rst;
  logic       drain;
  logic [4:0] outstanding;
  logic       idErr;

  fpu_offload_if #(.X_ID_WIDTH(4), .XLEN(32), .FLEN(32)) busIf ();

  fpu_offload_ctrl #(
    .X_ID_WIDTH(4), .XLEN(32), .FLEN(32), .MAX_OUTSTANDING(8), .BUBBLE_INSN(BUBBLE)
  ) dut (
    .ck            (ck),
    .rst           (rst),
    .i_drain       (drain),
    .if_bus        (busIf.slave),
    .o_outstanding (outstanding),
    .o_id_err      (idErr)
  );

  always #5 ck = ~ck;

  issueExp_t expIssue[$];
  wbExp_t    expWb[$];
  stExp_t    expSt[$];

  int   checkCount = 0;
  int   errorCount = 0;

  bit         mBusy [16];
  logic [4:0] mRd   [16];
  id_t        mNextId;
  int         mCount;
  bit         mRun;
  bit         mErr;

  // All comparisons funnel through here so the summary counts stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic bit tbIsFp(input logic [6:0] opc);
    case (opc)
      7'b0000111, 7'b0100111, 7'b1010011, 7'b1000011,
      7'b1000111, 7'b1001011, 7'b1001111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] fadd(input logic [4:0] rd);
    return {20'h0020F, rd, 7'b1010011};
  endfunction

  function automatic logic [31:0] flw(input logic [4:0] rd);
    return {12'h000, 5'd2, 3'b010, rd, 7'b0000111};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mBusy[i] = 1'b0;
      mRd[i]   = '0;
    end
    mNextId = '0;
    mCount  = 0;
    mRun    = 1'b1;
    mErr    = 1'b0;
  endtask

  task automatic clearInputs();
    busIf.issue_valid      = 1'b0;
    busIf.issue_instr      = '0;
    busIf.issue_rs1        = '0;
    busIf.issue_memdata    = '0;
    busIf.fpu_id_out       = '0;
    busIf.fpu_toXReg       = '0;
    busIf.fpu_toXReg_valid = 1'b0;
    busIf.fpu_toMem        = '0;
    busIf.fpu_toMem_valid  = 1'b0;
  endtask

  task automatic stageIssue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] mem);
    busIf.issue_valid   = 1'b1;
    busIf.issue_instr   = instr;
    busIf.issue_rs1     = rs1;
    busIf.issue_memdata = mem;
  endtask

  task automatic stageResult(input bit xv, input bit mv, input logic [3:0] id,
                             input logic [31:0] xd, input logic [31:0] md);
    busIf.fpu_toXReg_valid = xv;
    busIf.fpu_toMem_valid  = mv;
    busIf.fpu_id_out       = id;
    busIf.fpu_toXReg       = xd;
    busIf.fpu_toMem        = md;
  endtask

  // One clock with the staged inputs: predict, push expectations, update the
  // model at the edge, then check registered outputs half a cycle later.
  task automatic applyStimulus();
    bit          isFp, rdy, hs, hit, expEn;
    logic [3:0]  rid;
    issueExp_t   ie;
    hs  = 1'b0;
    hit = 1'b0;
    #1;
    isFp = tbIsFp(busIf.issue_instr[6:0]);
    if (busIf.issue_valid) begin
      rdy = isFp ? (mRun && busIf.fpu_ready && !mBusy[mNextId] && mCount < 8) : 1'b1;
      checkOutput("issue_ready", busIf.issue_ready, rdy);
      checkOutput("issue_accept", busIf.issue_accept, isFp);
      hs = isFp && rdy;
    end
    ie  = '{instr: busIf.issue_instr, id: mNextId, rs1: busIf.issue_rs1, mem: busIf.issue_memdata};
    rid = busIf.fpu_id_out;
    if (busIf.fpu_toXReg_valid || busIf.fpu_toMem_valid) begin
      if (mBusy[rid]) begin
        hit = 1'b1;
        if (busIf.fpu_toXReg_valid) expWb.push_back('{rd: mRd[rid], data: busIf.fpu_toXReg, id: rid});
        if (busIf.fpu_toMem_valid)  expSt.push_back('{data: busIf.fpu_toMem, id: rid});
      end else begin
        mErr = 1'b1;
      end
    end
    expEn = hs || (mCount > 0 && busIf.fpu_ready);
    @(posedge ck);
    if (hs) expIssue.push_back(ie);
    if (mRun && drain)                      mRun = 1'b0;
    else if (!mRun && !drain && mCount == 0) mRun = 1'b1;
    if (hs) begin
      mBusy[mNextId] = 1'b1;
      mRd[mNextId]   = ie.instr[11:7];
      mNextId        = mNextId + 1'b1;
      mCount++;
    end
    if (hit) begin
      mBusy[rid] = 1'b0;
      mCount--;
    end
    @(negedge ck);
    #2;
    checkOutput("fpu_enable", busIf.fpu_enable, expEn);
    if (expEn && !hs) checkOutput("bubble_insn", busIf.fpu_instruction, BUBBLE);
    checkOutput("outstanding", outstanding, mCount);
    checkOutput("id_err", idErr, mErr);
    clearInputs();
  endtask

  task automatic retireId(input int i);
    if (i % 2 == 1) stageResult(1'b0, 1'b1, 4'(i), 32'h0, 32'hB000_0000 + i);
    else            stageResult(1'b1, 1'b0, 4'(i), 32'hA000_0000 + i, 32'h0);
    applyStimulus();
  endtask

  task automatic retireAllExcept(input int keep);
    for (int i = 0; i < 16; i++) begin
      if (mBusy[i] && i != keep) retireId(i);
    end
  endtask

  task automatic issueMany(input int n, input int rdBase);
    for (int k = 0; k < n; k++) begin
      stageIssue((k % 2 == 0) ? fadd(5'(rdBase + k)) : flw(5'(rdBase + k)),
                 32'h1000_0000 + k, 32'h2000_0000 + k);
      applyStimulus();
    end
  endtask

  // Scoreboard side: every real FPU issue, writeback and store pops the queue.
  always @(negedge ck) begin : monitor
    issueExp_t ie;
    wbExp_t    we;
    stExp_t    se;
    if (!rst) begin
      if (busIf.fpu_enable && busIf.fpu_instruction !== BUBBLE) begin
        if (expIssue.size() == 0) checkOutput("unexpected_issue_qsize", 0, 1);
        else begin
          ie = expIssue.pop_front();
          checkOutput("fpu_instruction", busIf.fpu_instruction, ie.instr);
          checkOutput("fpu_id", busIf.fpu_id, ie.id);
          checkOutput("fpu_fromXReg", busIf.fpu_fromXReg, ie.rs1);
          checkOutput("fpu_fromMem", busIf.fpu_fromMem, ie.mem);
        end
      end
      if (busIf.wb_valid) begin
        if (expWb.size() == 0) checkOutput("unexpected_wb_qsize", 0, 1);
        else begin
          we = expWb.pop_front();
          checkOutput("wb_rd", busIf.wb_rd, we.rd);
          checkOutput("wb_data", busIf.wb_data, we.data);
          checkOutput("wb_id", busIf.wb_id, we.id);
        end
      end
      if (busIf.st_valid) begin
        if (expSt.size() == 0) checkOutput("unexpected_st_qsize", 0, 1);
        else begin
          se = expSt.pop_front();
          checkOutput("st_data", busIf.st_data, se.data);
          checkOutput("st_id", busIf.st_id, se.id);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    drain = 1'b0;
    busIf.fpu_ready = 1'b1;
    clearInputs();
    modelReset();
    repeat (2) @(posedge ck);
    @(negedge ck);
    #2;
    checkOutput("reset_outstanding", outstanding, 0);
    checkOutput("reset_fpu_enable", busIf.fpu_enable, 0);
    checkOutput("reset_wb_valid", busIf.wb_valid, 0);
    checkOutput("reset_st_valid", busIf.st_valid, 0);
    checkOutput("reset_id_err", idErr, 0);
    checkOutput("reset_issue_ready", busIf.issue_ready, 0);
    rst = 1'b0;

    $display("[TB] single FADD.S round trip");
    stageIssue(32'h0020_F0D3, 32'h1111_1111, 32'h2222_2222);
    applyStimulus();
    applyStimulus();
    stageResult(1'b1, 1'b0, 4'd0, 32'hCAFE_0001, 32'h0);
    applyStimulus();
    applyStimulus();

    $display("[TB] non-FP instruction stays in core");
    stageIssue(ADDI, 32'h5, 32'h6);
    applyStimulus();

    $display("[TB] outstanding limit and busy-entry blocking");
    issueMany(8, 2);
    stageIssue(fadd(5'd20), 32'h99, 32'h98);
    applyStimulus();
    stageIssue(fadd(5'd20), 32'h99, 32'h98);
    stageResult(1'b1, 1'b0, 4'd3, 32'hDEAD_0003, 32'h0);
    applyStimulus();
    stageIssue(fadd(5'd20), 32'h99, 32'h98);
    applyStimulus();
    retireAllExcept(2);
    issueMany(6, 10);
    retireAllExcept(2);
    issueMany(2, 24);
    stageIssue(fadd(5'd30), 32'h77, 32'h76);
    applyStimulus();
    stageIssue(fadd(5'd30), 32'h77, 32'h76);
    stageResult(1'b1, 1'b0, 4'd2, 32'hDEAD_0002, 32'h0);
    applyStimulus();
    stageIssue(fadd(5'd30), 32'h77, 32'h76);
    applyStimulus();
    retireAllExcept(-1);

    $display("[TB] FPU stall then bubble pumping");
    issueMany(2, 4);
    busIf.fpu_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      stageIssue(fadd(5'd9), 32'h44, 32'h45);
      applyStimulus();
    end
    busIf.fpu_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    stageResult(1'b1, 1'b1, mNextId - 4'd2, 32'h1234_5678, 32'h8765_4321);
    applyStimulus();
    retireAllExcept(-1);
    applyStimulus();

    $display("[TB] drain with work in flight");
    issueMany(3, 12);
    drain = 1'b1;
    applyStimulus();
    stageIssue(fadd(5'd7), 32'h1, 32'h2);
    applyStimulus();
    stageIssue(ADDI, 32'h3, 32'h4);
    applyStimulus();
    drain = 1'b0;
    stageIssue(fadd(5'd7), 32'h1, 32'h2);
    applyStimulus();
    retireAllExcept(-1);
    stageIssue(fadd(5'd7), 32'h1, 32'h2);
    applyStimulus();
    stageIssue(fadd(5'd7), 32'h1, 32'h2);
    applyStimulus();
    retireAllExcept(-1);
    applyStimulus();

    $display("[TB] result for a free id");
    stageResult(1'b0, 1'b1, 4'd5, 32'h0, 32'h5555_5555);
    applyStimulus();
    applyStimulus();

    $display("[TB] reset mid-burst");
    issueMany(3, 16);
    rst = 1'b1;
    #1;
    checkOutput("midrst_fpu_enable", busIf.fpu_enable, 0);
    checkOutput("midrst_outstanding", outstanding, 0);
    checkOutput("midrst_id_err", idErr, 0);
    checkOutput("midrst_wb_valid", busIf.wb_valid, 0);
    checkOutput("midrst_st_valid", busIf.st_valid, 0);
    modelReset();
    @(posedge ck);
    @(negedge ck);
    #2;
    rst = 1'b0;
    stageResult(1'b1, 1'b0, 4'd0, 32'hBAD0_0000, 32'h0);
    applyStimulus();
    applyStimulus();

    checkOutput("issue_queue_left", expIssue.size(), 0);
    checkOutput("wb_queue_left", expWb.size(), 0);
    checkOutput("st_queue_left", expSt.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
